// File: rtl/core5_onchip_memory_arbiter.sv
// Round-robin arbiter sharing one single-port on-chip RAM between several Avalon-MM masters.
// Zero-wait grant, 1-cycle read return, and a lock that holds only across back-to-back accesses.
module core5_onchip_memory_arbiter #(
  parameter int NUM_MASTERS = 5,
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_MASTERS-1:0]          m_read,
  input  logic [NUM_MASTERS-1:0]          m_write,
  input  logic [NUM_MASTERS-1:0]          m_lock,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_address,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_byteenable,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_writedata,
  output logic [NUM_MASTERS-1:0]          m_waitrequest,
  output logic [DATA_W-1:0]               m_readdata,
  output logic [NUM_MASTERS-1:0]          m_readdatavalid,
  output logic [ADDR_W-1:0]               mem_address,
  output logic [DATA_W/8-1:0]             mem_byteenable,
  output logic [DATA_W-1:0]               mem_writedata,
  output logic                            mem_chipselect,
  output logic                            mem_write,
  output logic                            mem_clken,
  input  logic [DATA_W-1:0]               mem_readdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       lock_owner;
  logic                   lock_owner_valid;
  logic                   rd_pend_valid;
  logic [IDX_W-1:0]       rd_pend_id;

  logic [NUM_MASTERS-1:0] req;
  logic                   grant_valid;
  logic [IDX_W-1:0]       grant_id;
  logic [NUM_MASTERS-1:0] granted;
  logic                   grant_is_read;
  logic                   owner_idle;
  logic [IDX_W-1:0]       ptr_after_grant;
  int                     idx;

  assign req = m_read | m_write;

  // Lock owner wins while it keeps requesting; otherwise first requester from rr_ptr upward.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = 0;
    if (lock_owner_valid && req[lock_owner]) begin
      grant_valid = 1'b1;
      grant_id    = lock_owner;
    end else begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
        if (!grant_valid && req[idx]) begin
          grant_valid = 1'b1;
          grant_id    = IDX_W'(idx);
        end
      end
    end
  end

  assign granted       = grant_valid ? (NUM_MASTERS'(1) << grant_id) : '0;
  assign m_waitrequest = ~granted;

  // A simultaneous read+write is treated as a write only.
  assign grant_is_read   = grant_valid & m_read[grant_id] & ~m_write[grant_id];
  assign owner_idle      = lock_owner_valid & ~req[lock_owner];
  assign ptr_after_grant = (grant_id == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_id + IDX_W'(1);

  assign mem_address    = m_address[grant_id*ADDR_W +: ADDR_W];
  assign mem_byteenable = m_byteenable[grant_id*BE_W +: BE_W];
  assign mem_writedata  = m_writedata[grant_id*DATA_W +: DATA_W];
  assign mem_chipselect = grant_valid & ~reset;
  assign mem_write      = grant_valid & m_write[grant_id] & ~reset;
  assign mem_clken      = 1'b1;

  // Gating with reset kills a return whose read was granted just before reset.
  assign m_readdata      = mem_readdata;
  assign m_readdatavalid = (rd_pend_valid && !reset) ? (NUM_MASTERS'(1) << rd_pend_id) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr           <= '0;
      lock_owner       <= '0;
      lock_owner_valid <= 1'b0;
      rd_pend_valid    <= 1'b0;
      rd_pend_id       <= '0;
    end else begin
      rd_pend_valid <= grant_is_read;
      if (grant_is_read) rd_pend_id <= grant_id;

      if (owner_idle) lock_owner_valid <= 1'b0;

      if (grant_valid) begin
        if (m_lock[grant_id]) begin
          lock_owner       <= grant_id;
          lock_owner_valid <= 1'b1;
        end else begin
          if (lock_owner_valid && grant_id == lock_owner) lock_owner_valid <= 1'b0;
          rr_ptr <= ptr_after_grant;
        end
      end
    end
  end

endmodule

// File: tb/tb_core5_onchip_memory_arbiter.sv
// Bench for the on-chip memory arbiter: behavioural RAM, read-return scoreboard, per-scenario tasks.
module tb_core5_onchip_memory_arbiter;

  localparam int NM = 5;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic            clk;
  logic            reset;
  logic [NM-1:0]   m_read, m_write, m_lock;
  logic [NM*AW-1:0] m_address;
  logic [NM*BW-1:0] m_byteenable;
  logic [NM*DW-1:0] m_writedata;
  logic [NM-1:0]   m_waitrequest;
  logic [DW-1:0]   m_readdata;
  logic [NM-1:0]   m_readdatavalid;
  logic [AW-1:0]   mem_address;
  logic [BW-1:0]   mem_byteenable;
  logic [DW-1:0]   mem_writedata;
  logic            mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0]   mem_readdata;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          id;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  core5_onchip_memory_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .m_read(m_read), .m_write(m_write), .m_lock(m_lock),
    .m_address(m_address), .m_byteenable(m_byteenable), .m_writedata(m_writedata),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: registered address, unregistered output, byte-enabled writes.
  logic [31:0] ram [0:8191];
  logic [12:0] rd_addr_q = '0;
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write)
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      rd_addr_q <= mem_address;
    end
  end
  assign mem_readdata = ram[rd_addr_q];

  // Read-return monitor: every readdatavalid pulse must match the oldest expected return.
  always @(negedge clk) begin
    if (m_readdatavalid !== '0) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rdv: got rdv=%b with no read outstanding", m_readdatavalid);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (m_readdatavalid !== (NM'(1) << e.id) || m_readdata !== e.data) begin
          bad++;
          $display("FAIL read_return: got rdv=%b data=%h, want rdv=%b data=%h",
                   m_readdatavalid, m_readdata, NM'(1) << e.id, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    m_read = '0; m_write = '0; m_lock = '0;
    m_address = '0; m_byteenable = '0; m_writedata = '0;
  endtask

  task automatic set_req(input int i, input logic rd, input logic wr, input logic lk,
                         input logic [12:0] a, input logic [3:0] be, input logic [31:0] d);
    m_read[i] = rd; m_write[i] = wr; m_lock[i] = lk;
    m_address[i*AW +: AW] = a;
    m_byteenable[i*BW +: BW] = be;
    m_writedata[i*DW +: DW] = d;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    next_cycle();
    next_cycle();
    @(negedge clk);
    total++;
    if (m_waitrequest !== 5'h1F || m_readdatavalid !== '0 || mem_chipselect !== 1'b0 || mem_clken !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: got wr=%b rdv=%b cs=%b clken=%b, want 11111 00000 0 1",
               m_waitrequest, m_readdatavalid, mem_chipselect, mem_clken);
    end
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_single_write_read();
    clear_inputs();
    set_req(2, 1'b0, 1'b1, 1'b0, 13'h0010, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    total++;
    if (m_waitrequest !== 5'b11011 || mem_write !== 1'b1 || mem_chipselect !== 1'b1 || mem_address !== 13'h0010) begin
      bad++;
      $display("FAIL single_write: got wr=%b mw=%b cs=%b addr=%h, want 11011 1 1 0010",
               m_waitrequest, mem_write, mem_chipselect, mem_address);
    end
    next_cycle();
    set_req(2, 1'b1, 1'b0, 1'b0, 13'h0010, 4'hF, 32'h0);
    @(negedge clk);
    total++;
    if (m_waitrequest !== 5'b11011 || mem_write !== 1'b0 || m_readdatavalid !== '0) begin
      bad++;
      $display("FAIL single_read_grant: got wr=%b mw=%b rdv=%b, want 11011 0 00000",
               m_waitrequest, mem_write, m_readdatavalid);
    end
    sb_q.push_back('{2, 32'hDEADBEEF});
    next_cycle();
    clear_inputs();
    @(negedge clk);
    total++;
    if (m_readdatavalid !== 5'b00100) begin
      bad++;
      $display("FAIL single_read_latency: got rdv=%b, want 00100", m_readdatavalid);
    end
    next_cycle();
  endtask

  task automatic test_all_read();
    // Prefill; the last write (master 4) leaves the pointer at 0.
    for (int i = 0; i < NM; i++) begin
      clear_inputs();
      set_req(i, 1'b0, 1'b1, 1'b0, 13'h0100 + 13'(i), 4'hF, 32'hA000_0000 + 32'(i));
      next_cycle();
    end
    clear_inputs();
    for (int i = 0; i < NM; i++) set_req(i, 1'b1, 1'b0, 1'b0, 13'h0100 + 13'(i), 4'hF, 32'h0);
    for (int c = 0; c < NM; c++) begin
      @(negedge clk);
      total++;
      if (m_waitrequest !== ~(NM'(1) << c) || mem_address !== 13'h0100 + 13'(c)) begin
        bad++;
        $display("FAIL all_read_grant%0d: got wr=%b addr=%h, want %b %h",
                 c, m_waitrequest, mem_address, ~(NM'(1) << c), 13'h0100 + 13'(c));
      end
      total++;
      if (m_readdatavalid !== ((c == 0) ? NM'(0) : (NM'(1) << (c - 1)))) begin
        bad++;
        $display("FAIL all_read_rdv%0d: got rdv=%b", c, m_readdatavalid);
      end
      sb_q.push_back('{c, 32'hA000_0000 + 32'(c)});
      next_cycle();
      m_read[c] = 1'b0;
    end
    @(negedge clk);
    total++;
    if (m_readdatavalid !== 5'b10000) begin
      bad++;
      $display("FAIL all_read_last_rdv: got rdv=%b, want 10000", m_readdatavalid);
    end
    next_cycle();
  endtask

  task automatic test_byteenable();
    clear_inputs();
    set_req(0, 1'b0, 1'b1, 1'b0, 13'h1FFF, 4'hF, 32'h11223344);
    next_cycle();
    set_req(0, 1'b0, 1'b1, 1'b0, 13'h1FFF, 4'h2, 32'h0000AB00);
    @(negedge clk);
    total++;
    if (mem_byteenable !== 4'h2 || mem_address !== 13'h1FFF || mem_writedata !== 32'h0000AB00) begin
      bad++;
      $display("FAIL be_drive: got be=%h addr=%h wd=%h, want 2 1fff 0000ab00",
               mem_byteenable, mem_address, mem_writedata);
    end
    next_cycle();
    set_req(0, 1'b1, 1'b0, 1'b0, 13'h1FFF, 4'hF, 32'h0);
    sb_q.push_back('{0, 32'h1122AB44});
    next_cycle();
    clear_inputs();
    @(negedge clk);
    total++;
    if (m_readdatavalid !== 5'b00001) begin
      bad++;
      $display("FAIL be_read_latency: got rdv=%b, want 00001", m_readdatavalid);
    end
    next_cycle();
  endtask

  task automatic test_lock();
    // Pointer is 1 here (last grant was master 0).
    clear_inputs();
    set_req(3, 1'b0, 1'b1, 1'b0, 13'h0300, 4'hF, 32'h3333_3333);
    for (int c = 0; c < 3; c++) begin
      set_req(1, 1'b0, 1'b1, (c < 2) ? 1'b1 : 1'b0, 13'h0200 + 13'(c), 4'hF, 32'h1111_0000 + 32'(c));
      @(negedge clk);
      total++;
      if (m_waitrequest !== 5'b11101) begin
        bad++;
        $display("FAIL lock_hold%0d: got wr=%b, want 11101", c, m_waitrequest);
      end
      next_cycle();
    end
    set_req(1, 1'b0, 1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
    @(negedge clk);
    total++;
    if (m_waitrequest !== 5'b10111) begin
      bad++;
      $display("FAIL lock_release_m3: got wr=%b, want 10111", m_waitrequest);
    end
    next_cycle();
    clear_inputs();
    set_req(0, 1'b0, 1'b1, 1'b0, 13'h0400, 4'hF, 32'h0);
    set_req(4, 1'b0, 1'b1, 1'b0, 13'h0404, 4'hF, 32'h4);
    @(negedge clk);
    total++;
    if (m_waitrequest !== 5'b01111) begin
      bad++;
      $display("FAIL lock_ptr_after: got wr=%b, want 01111 (pointer at 4)", m_waitrequest);
    end
    next_cycle();
    set_req(4, 1'b0, 1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
    @(negedge clk);
    total++;
    if (m_waitrequest !== 5'b11110) begin
      bad++;
      $display("FAIL lock_wrap: got wr=%b, want 11110", m_waitrequest);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_read_write_both();
    clear_inputs();
    set_req(0, 1'b1, 1'b1, 1'b0, 13'h0020, 4'hF, 32'h0000_0055);
    @(negedge clk);
    total++;
    if (mem_write !== 1'b1 || mem_chipselect !== 1'b1) begin
      bad++;
      $display("FAIL rw_both_write: got mw=%b cs=%b, want 1 1", mem_write, mem_chipselect);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    total++;
    if (m_readdatavalid !== '0) begin
      bad++;
      $display("FAIL rw_both_no_rdv: got rdv=%b, want 00000", m_readdatavalid);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    clear_inputs();
    set_req(1, 1'b0, 1'b1, 1'b1, 13'h0500, 4'hF, 32'h5);
    next_cycle();
    set_req(1, 1'b1, 1'b0, 1'b1, 13'h0500, 4'hF, 32'h0);
    @(negedge clk);
    total++;
    if (m_waitrequest !== 5'b11101) begin
      bad++;
      $display("FAIL rst_pre_grant: got wr=%b, want 11101", m_waitrequest);
    end
    next_cycle();
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (m_readdatavalid !== '0) begin
      bad++;
      $display("FAIL rst_kill_rdv: got rdv=%b, want 00000", m_readdatavalid);
    end
    next_cycle();
    reset = 1'b0;
    set_req(0, 1'b0, 1'b1, 1'b0, 13'h0600, 4'hF, 32'h6);
    set_req(1, 1'b0, 1'b1, 1'b0, 13'h0601, 4'hF, 32'h7);
    set_req(3, 1'b0, 1'b1, 1'b0, 13'h0603, 4'hF, 32'h8);
    @(negedge clk);
    total++;
    if (m_waitrequest !== 5'b11110 || m_readdatavalid !== '0) begin
      bad++;
      $display("FAIL rst_regrant: got wr=%b rdv=%b, want 11110 00000", m_waitrequest, m_readdatavalid);
    end
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    #1;
    test_reset();
    test_single_write_read();
    test_all_read();
    test_byteenable();
    test_lock();
    test_read_write_both();
    test_reset_mid_read();
    repeat (2) next_cycle();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d read returns never arrived, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core5_onchip_memory_arbiter.md
Name: core5_onchip_memory_arbiter

Overview:
- Round-robin arbiter sharing one single-port on-chip RAM (8192 x 32, byte enables, registered address, unregistered output, fixed 1-cycle read latency) between NUM_MASTERS core-side Avalon-MM masters.
- Sits between the per-core data masters and the RAM instance.
- Issues at most one RAM access per cycle, back-to-back.
- Routes read data to the owning master with a readdatavalid pulse.
- Supports a lock input for atomic multi-access sequences.

Parameters:
- NUM_MASTERS, 5: number of requesting masters, 2..8.
- ADDR_W, 13: word address width.
- DATA_W, 32: data width; byte-enable width is DATA_W/8.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- m_read  in  NUM_MASTERS  per-master read request.
- m_write  in  NUM_MASTERS  per-master write request.
- m_lock  in  NUM_MASTERS  per-master hold-grant request.
- m_address  in  NUM_MASTERS*ADDR_W  per-master word address; master i occupies slice i.
- m_byteenable  in  NUM_MASTERS*DATA_W/8  per-master byte enables.
- m_writedata  in  NUM_MASTERS*DATA_W  per-master write data.
- m_waitrequest  out  NUM_MASTERS  stall; master i must hold its request while its bit is high.
- m_readdata  out  DATA_W  shared read data bus, valid only when qualified by m_readdatavalid.
- m_readdatavalid  out  NUM_MASTERS  one-hot read-return strobe.
- mem_address  out  ADDR_W  RAM address.
- mem_byteenable  out  DATA_W/8  RAM byte enables.
- mem_writedata  out  DATA_W  RAM write data.
- mem_chipselect  out  1  RAM select.
- mem_write  out  1  RAM write.
- mem_clken  out  1  RAM clock enable; tied high.
- mem_readdata  in  DATA_W  RAM read data, valid the cycle after a read is issued.

Behaviour:
- Reset (synchronous, when reset=1 at a clk edge):
  - rr_ptr=0, lock_owner_valid=0, rd_pend_valid=0.
  - Outputs: m_readdatavalid=0 and mem_chipselect=0; m_waitrequest follows its combinational definition.
  - A read issued in the cycle reset is asserted never returns readdatavalid.
- Request of master i: req[i] = m_read[i] | m_write[i]. If both are set, the access is a write; a read is NOT issued.
- Grant (combinational, same cycle):
  - If lock_owner_valid and req[lock_owner], grant = lock_owner.
  - Otherwise grant goes to the first requester searching from rr_ptr upward, wrapping at NUM_MASTERS-1 -> 0.
  - At most one grant per cycle.
- Waitrequest and RAM drive:
  - m_waitrequest[i] = ~(granted[i]).
  - When no request is present, m_waitrequest is high for all masters (idle masters ignore it).
  - Granted master's address, byteenable and writedata are muxed to mem_*.
  - mem_chipselect=1 on any grant; mem_write=m_write of the granted master.
  - Zero-wait access: a request is accepted in the cycle it is granted.
- Pointer:
  - On each grant to master g without lock, rr_ptr <= (g+1) mod NUM_MASTERS at the clk edge.
  - Under a lock, rr_ptr is unchanged.
- Lock:
  - A granted access with m_lock[g]=1 sets lock_owner=g and lock_owner_valid=1.
  - A granted access by the owner with m_lock=0 clears lock_owner_valid; rr_ptr then advances past the owner.
  - While locked, the owner idling (req=0) clears the lock. This is a starvation guard: the lock holds only across back-to-back accesses.
- Read return:
  - A read granted at cycle T sets rd_pend_valid and rd_pend_id=g at edge T.
  - In cycle T+1: m_readdata=mem_readdata, m_readdatavalid[rd_pend_id]=1.
  - Reads by the same or different masters may issue every cycle; returns are in order with 1-cycle latency.
  - A write in T+1 does not disturb the T read return.
- Simultaneous requests: exactly one is served; the others stall with waitrequest=1 and must hold their request stable.
- Worst-case wait without locks: NUM_MASTERS-1 cycles.

Test Plan:
- Single master 2 writes 0xDEADBEEF to addr 0x0010 (be=0xF), then reads 0x0010 -> waitrequest[2]=0 in both request cycles; readdatavalid[2]=1 exactly one cycle after the read grant with m_readdata=0xDEADBEEF.
- All 5 masters assert read at once, rr_ptr=0 -> grants in order 0,1,2,3,4 on consecutive cycles; each readdatavalid one cycle after its grant; no gaps.
- Byte-enable write be=0x2 data 0x0000AB00 over 0x11223344 at 0x1FFF -> readback 0x1122AB44.
- Master 1 asserts lock for 3 back-to-back writes while master 3 requests -> master 3 waits 3 cycles, is granted in cycle 4, and rr_ptr=4 afterwards.
- Master 0 asserts read and write together -> mem_write=1; no readdatavalid pulse.
- Reset asserted the cycle after a read grant -> readdatavalid stays 0, rr_ptr=0, lock cleared; the next request is granted from master 0.
